// File: rtl/bioee_vector_player.sv
// Vector playback engine: circular buffer loaded by vec_write, replayed either as a
// consumed stream or as a repeating pattern, paced by a programmable divider.
module bioee_vector_player #(
  parameter int WIDTH = 32,
  parameter int AW    = 10
) (
  input  logic             vectorclk,
  input  logic             vectorreset,
  input  logic             vec_write,
  input  logic [WIDTH-1:0] vec_data,
  output logic             vec_ready,
  input  logic             mode,
  input  logic             start,
  input  logic             stop,
  input  logic             flush,
  input  logic [15:0]      rate_div,
  input  logic [AW:0]      loop_len,
  output logic [WIDTH-1:0] vectoroutput,
  output logic             running,
  output logic [AW:0]      fill_count,
  output logic             underflow,
  output logic             overflow
);
  localparam int          DEPTH = 1 << AW;
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] CONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PONE = AW'(1);

  typedef enum logic [1:0] {IDLE, STREAM, LOOP} state_t;

  typedef struct packed {
    logic [AW-1:0] base;
    logic [AW-1:0] ptr;
    logic [AW:0]   len;
    logic [AW:0]   cnt;
  } loop_ctx_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [15:0]      div_cnt;
  loop_ctx_t        lp;
  logic             do_flush, tick, push, pop, loop_go;

  assign running   = (state != IDLE);
  assign vec_ready = (fill_count < FULL) && (state != LOOP);
  assign do_flush  = flush && (state == IDLE);
  // stop masks the tick so the output freezes on the stop cycle itself
  assign tick      = running && !stop && (div_cnt == rate_div);
  assign push      = vec_write && vec_ready && !do_flush;
  assign pop       = (state == STREAM) && tick && (fill_count != '0);
  assign loop_go   = (state == IDLE) && (state_nxt == LOOP);

  always_ff @(posedge vectorclk or posedge vectorreset) begin
    if (vectorreset) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          if (!mode) state_nxt = STREAM;
          else if (loop_len != '0 && loop_len <= fill_count) state_nxt = LOOP;
        end
      end
      STREAM, LOOP: if (stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // storage is not reset; pointers and fill_count define what is valid
  always_ff @(posedge vectorclk) begin
    if (push) mem[wr_ptr] <= vec_data;
  end

  always_ff @(posedge vectorclk or posedge vectorreset) begin
    if (vectorreset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
    end else if (do_flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PONE;
      if (pop)  rd_ptr <= rd_ptr + PONE;
      case ({push, pop})
        2'b10:   fill_count <= fill_count + CONE;
        2'b01:   fill_count <= fill_count - CONE;
        default: fill_count <= fill_count;
      endcase
      if (vec_write && !vec_ready) overflow <= 1'b1;
      if ((state == STREAM) && tick && (fill_count == '0)) underflow <= 1'b1;
    end
  end

  // divider idles at 0, so the start cycle always leaves it cleared
  always_ff @(posedge vectorclk or posedge vectorreset) begin
    if (vectorreset)                                div_cnt <= '0;
    else if (state == IDLE || state_nxt == IDLE)    div_cnt <= '0;
    else if (tick)                                  div_cnt <= '0;
    else                                            div_cnt <= div_cnt + 16'd1;
  end

  always_ff @(posedge vectorclk or posedge vectorreset) begin
    if (vectorreset) begin
      vectoroutput <= '0;
    end else if (pop) begin
      vectoroutput <= mem[rd_ptr];
    end else if ((state == LOOP) && tick) begin
      vectoroutput <= mem[lp.ptr];
    end
  end

  always_ff @(posedge vectorclk or posedge vectorreset) begin
    if (vectorreset) begin
      lp <= '0;
    end else if (loop_go) begin
      lp.base <= rd_ptr;
      lp.ptr  <= rd_ptr;
      lp.len  <= loop_len;
      lp.cnt  <= '0;
    end else if ((state == LOOP) && tick) begin
      if (lp.cnt == lp.len - CONE) begin
        lp.ptr <= lp.base;
        lp.cnt <= '0;
      end else begin
        lp.ptr <= lp.ptr + PONE;
        lp.cnt <= lp.cnt + CONE;
      end
    end
  end

endmodule

// File: tb/tb_bioee_vector_player.sv
// Bench for bioee_vector_player: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bioee_vector_player;
  localparam int WIDTH = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             vec_write = 1'b0;
  logic [WIDTH-1:0] vec_data = '0;
  logic             vec_ready;
  logic             mode = 1'b0, start = 1'b0, stop = 1'b0, flush = 1'b0;
  logic [15:0]      rate_div = '0;
  logic [AW:0]      loop_len = '0;
  logic [WIDTH-1:0] vectoroutput;
  logic             running;
  logic [AW:0]      fill_count;
  logic             underflow, overflow;

  always #5 clk = ~clk;

  bioee_vector_player #(.WIDTH(WIDTH), .AW(AW)) dut (
    .vectorclk(clk), .vectorreset(rst),
    .vec_write(vec_write), .vec_data(vec_data), .vec_ready(vec_ready),
    .mode(mode), .start(start), .stop(stop), .flush(flush),
    .rate_div(rate_div), .loop_len(loop_len),
    .vectoroutput(vectoroutput), .running(running), .fill_count(fill_count),
    .underflow(underflow), .overflow(overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffer as a queue, playback as 0=idle 1=stream 2=loop
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_out;
  int m_run, m_cnt, m_idx, m_len;
  bit m_under, m_over;

  function automatic void model_reset();
    m_q.delete();
    m_out = '0; m_run = 0; m_cnt = 0; m_idx = 0; m_len = 0;
    m_under = 0; m_over = 0;
  endfunction

  function automatic void model_step();
    int sz = m_q.size();
    bit ready = (sz < DEPTH) && (m_run != 2);
    bit tk = (m_run != 0) && !stop && (m_cnt == int'(rate_div));
    int nrun = m_run;
    if (m_run == 0 && flush) begin
      m_q.delete(); m_under = 0; m_over = 0;
    end else begin
      if (m_run == 1 && tk) begin
        if (sz > 0) m_out = m_q.pop_front();
        else        m_under = 1;
      end
      if (m_run == 2 && tk) begin
        m_out = m_q[m_idx];
        m_idx = (m_idx + 1) % m_len;
      end
      if (vec_write) begin
        if (ready) m_q.push_back(vec_data);
        else       m_over = 1;
      end
    end
    if (m_run == 0 || stop || tk) m_cnt = 0;
    else                          m_cnt++;
    if (m_run == 0) begin
      if (start && !stop) begin
        if (!mode) nrun = 1;
        else if (int'(loop_len) >= 1 && int'(loop_len) <= sz) begin
          nrun = 2; m_len = int'(loop_len); m_idx = 0;
        end
      end
    end else if (stop) nrun = 0;
    m_run = nrun;
  endfunction

  always @(posedge clk) begin
    if (!rst) model_step();
    #1;
    if (!rst) begin
      chk("vectoroutput", vectoroutput, m_out);
      chk("running", running, m_run != 0);
      chk("fill_count", fill_count, m_q.size());
      chk("underflow", underflow, m_under);
      chk("overflow", overflow, m_over);
      chk("vec_ready", vec_ready, (m_q.size() < DEPTH) && (m_run != 2));
    end
  end

  task automatic wr(input logic [WIDTH-1:0] d);
    vec_write = 1'b1; vec_data = d;
    @(negedge clk);
    vec_write = 1'b0;
  endtask

  task automatic pulse_start(input logic m, input int len, input int rd);
    mode = m; loop_len = (AW+1)'(len); rate_div = 16'(rd); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  logic [WIDTH-1:0] exp_loop [8];

  initial begin
    model_reset();
    @(negedge clk);
    chk("reset_out", vectoroutput, 0);
    chk("reset_running", running, 0);
    chk("reset_fill", fill_count, 0);
    chk("reset_ready", vec_ready, 1);
    chk("reset_flags", {underflow, overflow}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // stream of three words, rate_div 0
    wr(32'hA); wr(32'hB); wr(32'hC);
    pulse_start(1'b0, 0, 0);
    @(negedge clk); chk("stream_w0", vectoroutput, 32'hA);
    @(negedge clk); chk("stream_w1", vectoroutput, 32'hB);
    @(negedge clk); chk("stream_w2", vectoroutput, 32'hC);
    @(negedge clk);
    chk("stream_hold", vectoroutput, 32'hC);
    chk("stream_under", underflow, 1);
    chk("stream_fill", fill_count, 0);
    pulse_stop();
    pulse_flush();
    chk("flush_under", underflow, 0);

    // loop of three words, rate_div 1
    wr(32'hA); wr(32'hB); wr(32'hC);
    pulse_start(1'b1, 3, 1);
    exp_loop = '{32'hA, 32'hA, 32'hB, 32'hB, 32'hC, 32'hC, 32'hA, 32'hA};
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("loop_seq", vectoroutput, exp_loop[i]);
      chk("loop_fill", fill_count, 3);
    end
    pulse_stop();
    pulse_flush();

    // fill to DEPTH, then one rejected word
    for (int i = 0; i < DEPTH; i++) begin
      vec_write = 1'b1; vec_data = 32'h100 + i;
      @(negedge clk);
    end
    vec_write = 1'b0;
    chk("full_ready", vec_ready, 0);
    chk("full_fill", fill_count, DEPTH);
    wr(32'hDEAD);
    chk("full_over", overflow, 1);
    chk("full_fill2", fill_count, DEPTH);
    pulse_start(1'b0, 0, 0);
    repeat (DEPTH + 3) @(negedge clk);
    chk("drain_last", vectoroutput, 32'h100 + DEPTH - 1);
    chk("drain_under", underflow, 1);
    pulse_stop();
    pulse_flush();

    // loop start rejected
    wr(32'h51); wr(32'h52); wr(32'h53);
    pulse_start(1'b1, 5, 0);
    chk("loop_len_big", running, 0);
    pulse_start(1'b1, 0, 0);
    chk("loop_len_zero", running, 0);

    // stop with start while looping; write during loop overflows
    pulse_start(1'b1, 3, 0);
    wr(32'hBAD);
    stop = 1'b1; start = 1'b1; mode = 1'b0;
    @(negedge clk);
    stop = 1'b0; start = 1'b0;
    chk("stopstart_run", running, 0);
    chk("stopstart_out", vectoroutput, 32'h51);
    chk("loop_over", overflow, 1);
    @(negedge clk);
    chk("stop_hold", vectoroutput, 32'h51);
    pulse_flush();
    chk("flush_fill", fill_count, 0);
    chk("flush_flags", {underflow, overflow}, 0);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      vec_write = ($urandom_range(0, 99) < 40);
      vec_data  = $urandom;
      flush = ($urandom_range(0, 24) == 0);
      start = ($urandom_range(0, 14) == 0) && !flush;
      stop  = ($urandom_range(0, 39) == 0);
      mode  = $urandom_range(0, 1);
      loop_len = (AW+1)'($urandom_range(0, 8));
      if (m_run == 0) rate_div = 16'($urandom_range(0, 3));
      @(negedge clk);
    end
    vec_write = 1'b0; flush = 1'b0; start = 1'b0; stop = 1'b0;
    @(negedge clk);
    pulse_stop();
    pulse_flush();

    // asynchronous reset mid-loop
    wr(32'h61); wr(32'h62); wr(32'h63);
    pulse_start(1'b1, 2, 0);
    repeat (3) @(negedge clk);
    chk("pre_reset_run", running, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_out", vectoroutput, 0);
    chk("async_running", running, 0);
    chk("async_fill", fill_count, 0);
    chk("async_ready", vec_ready, 1);
    chk("async_flags", {underflow, overflow}, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wr(32'h71);
    pulse_start(1'b0, 0, 0);
    repeat (3) @(negedge clk);
    chk("post_reset_out", vectoroutput, 32'h71);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
